// File: rtl/risc_pkg.sv
// Shared definitions for the parametrised multicycle RISC core:
// opcodes, FSM state encoding, IR field positions, status bit indices.
package risc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LDI = 4'h8,
    OP_LD  = 4'h9,
    OP_ST  = 4'hA,
    OP_JMP = 4'hB,
    OP_JZ  = 4'hC,
    OP_JC  = 4'hD,
    OP_JN  = 4'hE,
    OP_HLT = 4'hF
  } op_t;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int W_MSB    = 11;
  localparam int W_LSB    = 9;
  localparam int R_MSB    = 8;
  localparam int R_LSB    = 6;
  localparam int S_MSB    = 5;
  localparam int S_LSB    = 3;
  localparam int IMM_MSB  = 8;
  localparam int OFS_MSB  = 11;

  localparam int SB_BUS_ERR = 7;
  localparam int SB_HALTED  = 6;
  localparam int SB_C       = 2;
  localparam int SB_Z       = 1;
  localparam int SB_N       = 0;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: add/sub/logic/shift with N, Z, C flags.
// Non-ALU opcodes produce zero with C cleared.
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] sum;

  // Result and carry/borrow per opcode
  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      default: ;
    endcase
  end

  assign n = result[DATA_W-1];
  assign z = (result == '0);

endmodule

// File: rtl/risc_core_param.sv
// Multicycle RISC core with req/ack memory port and halt.
// Define BUS_TIMEOUT_EN to add the bus wait timeout (sticky bus_err).
module risc_core_param
  import risc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_ADR_W   = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_in,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] d_out,
  output logic [7:0]        status,
  output logic              halted
);

  localparam int NREG = 1 << REG_ADR_W;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                flag_n;
  logic                flag_z;
  logic                flag_c;
  logic                bus_err_q;

  logic [3:0]           op;
  logic [REG_ADR_W-1:0] w_a;
  logic [REG_ADR_W-1:0] r_a;
  logic [REG_ADR_W-1:0] s_a;
  logic [DATA_W-1:0]    imm;
  logic [ADDR_W-1:0]    ofs;
  logic [ADDR_W-1:0]    pc_next;

  logic [DATA_W-1:0] alu_res;
  logic              alu_n;
  logic              alu_z;
  logic              alu_c;
  logic              timeout;

  assign op  = ir[OP_MSB:OP_LSB];
  assign w_a = ir[W_MSB:W_LSB];
  assign r_a = ir[R_MSB:R_LSB];
  assign s_a = ir[S_MSB:S_LSB];
  assign imm = {{(DATA_W-9){ir[IMM_MSB]}}, ir[IMM_MSB:0]};
  assign ofs = {{(ADDR_W-12){ir[OFS_MSB]}}, ir[OFS_MSB:0]};

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout = mem_req && !mem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count consecutive unacknowledged request cycles
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (mem_req && !mem_ack)
      wait_cnt <= wait_cnt + CNT_W'(1);
    else
      wait_cnt <= '0;
  end
`else
  // No timeout in this build: a negative limit is never meaningful
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // Branch target; pc already points past the branch
  always_comb begin
    pc_next = pc;
    unique case (1'b1)
      op == OP_JMP:
        pc_next = a_q[ADDR_W-1:0];
      (op == OP_JZ && flag_z) ||
      (op == OP_JC && flag_c) ||
      (op == OP_JN && flag_n):
        pc_next = pc + ofs;
      default: ;
    endcase
  end

  // Main FSM with registered memory port and architectural state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      bus_err_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      address   <= '0;
      d_out     <= '0;
      halted    <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (timeout) begin
            mem_req   <= 1'b0;
            bus_err_q <= 1'b1;
            halted    <= 1'b1;
            state     <= ST_HALT;
          end else if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            address <= pc;
          end else if (mem_ack) begin
            ir      <= d_in[15:0];
            pc      <= pc + ADDR_W'(1);
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q <= regs[r_a];
          b_q <= regs[s_a];
          unique case (1'b1)
            op == OP_LD || op == OP_ST: begin
              mem_req <= 1'b1;
              mem_we  <= (op == OP_ST);
              address <= regs[r_a][ADDR_W-1:0];
              d_out   <= regs[w_a];
              state   <= ST_MEM;
            end
            op == OP_HLT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: state <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          if (is_alu(op)) begin
            regs[w_a] <= alu_res;
            flag_n    <= alu_n;
            flag_z    <= alu_z;
            flag_c    <= alu_c;
          end else if (op == OP_LDI) begin
            regs[w_a] <= imm;
          end
          pc      <= pc_next;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
          address <= pc_next;
          state   <= ST_FETCH;
        end
        ST_MEM: begin
          if (timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            bus_err_q <= 1'b1;
            halted    <= 1'b1;
            state     <= ST_HALT;
          end else if (mem_ack) begin
            if (!mem_we)
              regs[w_a] <= d_in;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            address <= pc;
            state   <= ST_FETCH;
          end
        end
        ST_HALT: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          halted  <= 1'b1;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign status = {bus_err_q, halted, state,
                   flag_c, flag_z, flag_n};

endmodule

// File: tb/tb_risc_core_param.sv
// Directed bench for risc_core_param with a req/ack memory model.
// Data region 0x20..0xFF can be given wait states.
module tb_risc_core_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] d_in;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] address;
  logic [15:0] d_out;
  logic [7:0]  status;
  logic        halted;

  logic [15:0] mem [65536];
  int          wait_n = 0;
  logic        never_ack = 1'b0;
  int          wcnt = 0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] read_q [$];
  int          dreq;
  int          unstable;
  int          st_cnt;
  logic [15:0] st_addr;
  logic [15:0] st_data;

  risc_core_param dut (
    .clk     (clk),
    .reset   (reset),
    .d_in    (d_in),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .address (address),
    .d_out   (d_out),
    .status  (status),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  assign d_in = mem[address];

  always_comb begin
    mem_ack = 1'b0;
    if (mem_req && !never_ack) begin
      if (address >= 16'h0020 && address < 16'h0100)
        mem_ack = (wcnt >= wait_n);
      else
        mem_ack = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ack)
      wcnt <= wcnt + 1;
    else
      wcnt <= 0;
  end

  function automatic logic [15:0] enc(
    input logic [3:0] op, input int w, input int r, input int s);
    return {op, 3'(w), 3'(r), 3'(s), 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int w, input int v);
    return {4'h8, 3'(w), 9'(v)};
  endfunction

  function automatic logic [15:0] br(input logic [3:0] op, input int o);
    return {op, 12'(o)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++)
      mem[i] = 16'h0000;
  endtask

  task automatic run_prog(input int max_cyc, output int cyc);
    logic        pend;
    logic [15:0] paddr;
    logic        pwe;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    read_q.delete();
    dreq = 0;
    unstable = 0;
    st_cnt = 0;
    pend = 1'b0;
    paddr = '0;
    pwe = 1'b0;
    cyc = 0;
    while (!halted && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (pend && (address !== paddr || mem_we !== pwe))
        unstable++;
      pend = mem_req && !mem_ack;
      paddr = address;
      pwe = mem_we;
      if (mem_req && mem_ack && !mem_we)
        read_q.push_back(address);
      if (mem_req && mem_we) begin
        st_cnt++;
        st_addr = address;
        st_data = d_out;
      end
      if (mem_req && address == 16'h0020)
        dreq++;
      if (mem_req && mem_ack && mem_we)
        mem[address] = d_out;
    end
    n_cmp++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL run_halt: no halt within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (status !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_status got %h exp 00", status);
    end
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req got %b exp 0", mem_req);
    end
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_we got %b exp 0", mem_we);
    end
    n_cmp++;
    if (address !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_addr got %h exp 0000", address);
    end
    n_cmp++;
    if (d_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_dout got %h exp 0000", d_out);
    end
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_halted got %b exp 0", halted);
    end
  endtask

  task automatic test_add();
    int cyc;
    clear_mem();
    wait_n = 0;
    mem[0] = ldi(1, 5);
    mem[1] = ldi(2, 3);
    mem[2] = enc(4'h1, 3, 1, 2);
    mem[3] = 16'hF000;
    run_prog(60, cyc);
    n_cmp++;
    if (cyc !== 12) begin
      n_fail++;
      $display("FAIL add_cycles got %0d exp 12", cyc);
    end
    n_cmp++;
    if (dut.regs[3] !== 16'h0008) begin
      n_fail++;
      $display("FAIL add_r3 got %h exp 0008", dut.regs[3]);
    end
    n_cmp++;
    if (status !== 8'h60) begin
      n_fail++;
      $display("FAIL add_status got %h exp 60", status);
    end
    n_cmp++;
    if (read_q.size() !== 4) begin
      n_fail++;
      $display("FAIL add_nfetch got %0d exp 4", read_q.size());
    end
    for (int i = 0; i < read_q.size() && i < 4; i++) begin
      n_cmp++;
      if (read_q[i] !== 16'(i)) begin
        n_fail++;
        $display("FAIL add_fetch%0d got %h exp %h", i, read_q[i], 16'(i));
      end
    end
  endtask

  task automatic test_sub();
    int cyc;
    clear_mem();
    mem[0] = ldi(1, 5);
    mem[1] = ldi(2, 3);
    mem[2] = enc(4'h2, 3, 2, 1);
    mem[3] = 16'hF000;
    run_prog(60, cyc);
    n_cmp++;
    if (dut.regs[3] !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sub_r3 got %h exp FFFE", dut.regs[3]);
    end
    n_cmp++;
    if (status[2:0] !== 3'b101) begin
      n_fail++;
      $display("FAIL sub_czn got %b exp 101", status[2:0]);
    end
    clear_mem();
    mem[0] = ldi(1, 5);
    mem[1] = enc(4'h2, 0, 1, 1);
    mem[2] = 16'hF000;
    run_prog(60, cyc);
    n_cmp++;
    if (dut.regs[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL sub0_r0 got %h exp 0000", dut.regs[0]);
    end
    n_cmp++;
    if (status[2:0] !== 3'b010) begin
      n_fail++;
      $display("FAIL sub0_czn got %b exp 010", status[2:0]);
    end
  endtask

  task automatic test_logic();
    int cyc;
    logic [15:0] exp_r [8];
    clear_mem();
    mem[0] = ldi(1, 'h0F0);
    mem[1] = ldi(2, -1);
    mem[2] = enc(4'h3, 3, 1, 2);
    mem[3] = enc(4'h4, 4, 1, 2);
    mem[4] = enc(4'h5, 5, 1, 2);
    mem[5] = enc(4'h6, 6, 2, 0);
    mem[6] = enc(4'h7, 7, 1, 0);
    mem[7] = 16'hF000;
    exp_r[3] = 16'h00F0;
    exp_r[4] = 16'hFFFF;
    exp_r[5] = 16'hFF0F;
    exp_r[6] = 16'hFFFE;
    exp_r[7] = 16'h0078;
    run_prog(100, cyc);
    for (int i = 3; i < 8; i++) begin
      n_cmp++;
      if (dut.regs[i] !== exp_r[i]) begin
        n_fail++;
        $display("FAIL logic_r%0d got %h exp %h", i, dut.regs[i], exp_r[i]);
      end
    end
    n_cmp++;
    if (status[2:0] !== 3'b000) begin
      n_fail++;
      $display("FAIL logic_czn got %b exp 000", status[2:0]);
    end
  endtask

  task automatic test_ld_wait();
    int cyc;
    clear_mem();
    wait_n = 3;
    mem[16'h20] = 16'h1234;
    mem[0] = ldi(1, 'h20);
    mem[1] = enc(4'h9, 2, 1, 0);
    mem[2] = 16'hF000;
    run_prog(60, cyc);
    wait_n = 0;
    n_cmp++;
    if (dut.regs[2] !== 16'h1234) begin
      n_fail++;
      $display("FAIL ld_r2 got %h exp 1234", dut.regs[2]);
    end
    n_cmp++;
    if (dreq !== 4) begin
      n_fail++;
      $display("FAIL ld_req_cycles got %0d exp 4", dreq);
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL ld_stable got %0d changes exp 0", unstable);
    end
    n_cmp++;
    if (cyc !== 12) begin
      n_fail++;
      $display("FAIL ld_cycles got %0d exp 12", cyc);
    end
  endtask

  task automatic test_store();
    int cyc;
    clear_mem();
    mem[16'h30] = 16'hBEEF;
    mem[0] = ldi(1, 'h30);
    mem[1] = enc(4'h9, 4, 1, 0);
    mem[2] = ldi(5, 'h40);
    mem[3] = enc(4'hA, 4, 5, 0);
    mem[4] = 16'hF000;
    run_prog(80, cyc);
    n_cmp++;
    if (st_cnt !== 1) begin
      n_fail++;
      $display("FAIL st_cycles got %0d exp 1", st_cnt);
    end
    n_cmp++;
    if (st_addr !== 16'h0040) begin
      n_fail++;
      $display("FAIL st_addr got %h exp 0040", st_addr);
    end
    n_cmp++;
    if (st_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL st_data got %h exp BEEF", st_data);
    end
    n_cmp++;
    if (mem[16'h40] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL st_mem got %h exp BEEF", mem[16'h40]);
    end
  endtask

  task automatic check_seq(input string nm, input logic [15:0] e [$]);
    n_cmp++;
    if (read_q.size() !== e.size()) begin
      n_fail++;
      $display("FAIL %s_len got %0d exp %0d", nm, read_q.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < read_q.size(); i++) begin
      n_cmp++;
      if (read_q[i] !== e[i]) begin
        n_fail++;
        $display("FAIL %s_%0d got %h exp %h", nm, i, read_q[i], e[i]);
      end
    end
  endtask

  task automatic test_branch();
    int cyc;
    logic [15:0] e [$];
    clear_mem();
    mem[0]  = ldi(6, 10);
    mem[1]  = enc(4'h2, 0, 0, 0);
    mem[2]  = enc(4'hB, 0, 6, 0);
    mem[10] = br(4'hC, -2);
    mem[9]  = 16'hF000;
    run_prog(80, cyc);
    e = '{16'd0, 16'd1, 16'd2, 16'd10, 16'd9};
    check_seq("jz_taken", e);
    clear_mem();
    mem[0]  = ldi(6, 10);
    mem[1]  = ldi(1, 1);
    mem[2]  = enc(4'h4, 0, 1, 1);
    mem[3]  = enc(4'hB, 0, 6, 0);
    mem[10] = br(4'hC, -2);
    mem[11] = 16'hF000;
    run_prog(80, cyc);
    e = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd10, 16'd11};
    check_seq("jz_fall", e);
    clear_mem();
    mem[0]        = br(4'hE, 3);
    mem[1]        = ldi(6, -1);
    mem[2]        = enc(4'hB, 0, 6, 0);
    mem[16'hFFFF] = enc(4'h6, 1, 6, 0);
    mem[4]        = 16'hF000;
    run_prog(80, cyc);
    e = '{16'd0, 16'd1, 16'd2, 16'hFFFF, 16'd0, 16'd4};
    check_seq("jmp_wrap", e);
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    clear_mem();
    never_ack = 1'b1;
    run_prog(60, cyc);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL to_req got %b exp 0", mem_req);
    end
    n_cmp++;
    if (status[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL to_buserr got %b exp 1", status[7]);
    end
    never_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (status[7:6] !== 2'b00) begin
      n_fail++;
      $display("FAIL to_clear got %b exp 00", status[7:6]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_ld_wait();
    test_store();
    test_branch();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
